hpdcache_flush_pwb: RTL and testbench
=====================================

HPDCACHE_FLUSH_PWB -- requirements
Module: hpdcache_flush_pwb

Interface
REQ-001 SHALL have parameter NLINE_W, default 26, cacheline number width.
REQ-002 SHALL have parameter SET_W, default 7, set index width; set = nline[SET_W-1:0].
REQ-003 SHALL have parameter WAYS, default 4, way count; way vectors are one-hot.
REQ-004 SHALL have parameter CL_WORDS, default 8, words per line; power of 2.
REQ-005 SHALL have parameter AW, default 2, words per cache read; power of 2; AW <= CL_WORDS.
REQ-006 SHALL have parameter WORD_W, default 64, word width in bits.
REQ-007 SHALL have parameter ENTRIES, default 4, directory depth; any value >= 1, need not be a power of 2.
REQ-008 SHALL have parameter PARTIAL_WB, default 1, partial write-back mode:
- 1: byte enables come from the dirty mask.
- 0: all byte enables are 1.
REQ-009 SHALL derive the following: FW = AW*WORD_W; F = CL_WORDS/AW flits per line; BW = CL_WORDS*WORD_W/8; ID_W = max(1, clog2(ENTRIES)).
REQ-010 SHALL have ports clk_i in 1 clock; rst_ni in 1 reset. Reset rst_ni is asynchronous, active-low; clock clk_i.
REQ-011 SHALL have status ports:
- empty_o out 1: no valid entry.
- full_o out 1: all entries valid.
- busy_o out 1: FSM not IDLE.
REQ-012 SHALL have check ports check_nline_i in NLINE_W and check_hit_o out 1.
REQ-013 SHALL have alloc ports:
- alloc_i in 1; alloc_ready_o out 1.
- alloc_nline_i in NLINE_W; alloc_way_i in WAYS.
- alloc_be_i in BW: dirty byte mask, bit b covers line byte b.
REQ-014 SHALL have cache read ports rd_o out 1; rd_set_o out SET_W; rd_word_o out clog2(CL_WORDS); rd_way_o out WAYS; rd_data_i in FW.
REQ-015 SHALL have ack ports ack_o out 1; ack_nline_o out NLINE_W; ack_err_o out 1.
REQ-016 SHALL have memory request ports mem_req_valid_o out 1; mem_req_ready_i in 1; mem_req_addr_o out NLINE_W+clog2(BW); mem_req_len_o out 8; mem_req_id_o out ID_W.
REQ-017 SHALL have write data ports mem_w_valid_o out 1; mem_w_ready_i in 1; mem_w_data_o out FW; mem_w_be_o out FW/8; mem_w_last_o out 1.
REQ-018 SHALL have response ports mem_resp_valid_i in 1; mem_resp_id_i in ID_W; mem_resp_err_i in 1. Responses are always accepted.

Function
REQ-019 SHALL implement FSM IDLE -> SEND -> IDLE. busy_o = (state == SEND).
REQ-020 SHALL drive alloc_ready_o = IDLE & ~full_o & ~mem_req_valid_o. Exception: a clean alloc (PARTIAL_WB=1 and alloc_be_i == 0) is ready in IDLE even when full.
REQ-021 SHALL, on a clean alloc handshake, allocate nothing, issue no read and no request, and stay in IDLE.
REQ-022 SHALL, on any other alloc handshake, do all of the following in the same cycle:
- take the lowest-index free entry and store its nline.
- latch set, way and BE mask.
- set mem_req_valid_o from the next cycle: addr = {nline, 0}, len = F-1, id = entry index.
- assert rd_o with word 0.
- go to SEND.
REQ-023 SHALL hold mem_req_valid_o and its fields until the cycle mem_req_ready_i = 1. The request channel is independent of the data channel.
REQ-024 SHALL return read data on rd_data_i exactly 1 cycle after rd_o and capture it into a single data output register.
REQ-025 SHALL, in SEND, assert rd_o at cycle t only when all of these hold:
- no read is pending.
- the output register is empty or is handshaking at t.
- flits remain.
rd_word_o advances by AW per read.
REQ-026 SHALL drive mem_w_be_o for flit k from BE mask bytes [k*FW/8 +: FW/8] when PARTIAL_WB=1, else all ones. A flit with zero BE is still sent.
REQ-027 SHALL assert mem_w_last_o on flit F-1 and return to IDLE after the last flit handshake.
REQ-028 SHALL hold mem_w_valid_o and mem_w_data_o stable until mem_w_ready_i = 1.
REQ-029 SHALL, on mem_resp_valid_i, drive the following combinationally in that cycle:
- ack_o = 1.
- ack_nline_o = nline of entry mem_resp_id_i.
- ack_err_o = mem_resp_err_i.
The entry is freed at the next edge. An error does not retain the entry.
REQ-030 SHALL drive check_hit_o = OR over entries of (valid & ~acked-this-cycle & nline == check_nline_i).
REQ-031 SHALL handle alloc and ack in the same cycle independently:
- the freed entry is not reused in that cycle.
- with full_o = 1, alloc stays blocked that cycle.
REQ-032 SHALL ignore a response to an invalid entry or an id >= ENTRIES: no ack_o, no state change.
REQ-033 SHALL start the next line's request only after the previous request is accepted. Up to ENTRIES writes may be outstanding.

Reset
REQ-034 SHALL, on rst_ni = 0, asynchronously:
- clear all valid bits, the FSM state (IDLE), the pending-read flag, the output-register valid, the flit counter and mem_req_valid_o.
- drive all outputs 0 except empty_o = 1.
- cancel an in-progress SEND: no further flits are sent after reset.
REQ-035 SHALL NOT reset the nline, set, way, BE and data storage.

Verification
REQ-036 SHALL cover this scenario with defaults: alloc nline 0x123, all-ones BE, ready held 1 -> one request (addr = 0x123<<6, len 3, id 0), 4 flits with BE 0xFFFF and last on the 4th, busy_o deasserted after the last flit.
REQ-037 SHALL cover this scenario: BE with only byte 20 set -> flit 1 BE = 0x0010, other flits BE 0.
REQ-038 SHALL cover this scenario: alloc with BE = 0 while full_o = 1 -> handshake completes, no request, empty_o/full_o unchanged.
REQ-039 SHALL cover this scenario: ENTRIES = 3, fill 3 lines, then mem_resp id 1 with err = 1 -> ack_o = 1, ack_err_o = 1, ack_nline_o = line 1, check_hit_o = 0 for line 1 in that cycle, and the next alloc uses entry 1.
REQ-040 SHALL cover this scenario: mem_w_ready_i toggling 1/0 -> no flit lost or duplicated and data stable while stalled.
REQ-041 SHALL cover this scenario: rst_ni asserted after flit 2 -> all outputs 0 and empty_o = 1 within the same cycle, and no flit 3.

Source files
------------

// File: rtl/hpdcache_flush_pwb.sv
// Flush/partial write-back buffer for the HPDcache.
// Tracks outstanding line write-backs in a small directory, streams each
// dirty line from the cache data array to memory flit by flit, and
// acknowledges lines when memory responds.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   empty_o/full_o/busy_o    directory and FSM status
//   check_*                  lookup of a line in the directory
//   alloc_*                  new write-back request (dirty byte mask in alloc_be_i)
//   rd_*                     cache data read port (data returns one cycle later)
//   ack_*                    line acknowledge on memory response
//   mem_req_*                write request channel (address, length, id)
//   mem_w_*                  write data channel
//   mem_resp_*               write response channel (always accepted)
module hpdcache_flush_pwb #(
   parameter int unsigned NLINE_W    = 26,
   parameter int unsigned SET_W      = 7,
   parameter int unsigned WAYS       = 4,
   parameter int unsigned CL_WORDS   = 8,
   parameter int unsigned AW         = 2,
   parameter int unsigned WORD_W     = 64,
   parameter int unsigned ENTRIES    = 4,
   parameter int unsigned PARTIAL_WB = 1,
   localparam int unsigned FW         = AW * WORD_W,
   localparam int unsigned F          = CL_WORDS / AW,
   localparam int unsigned BW         = CL_WORDS * WORD_W / 8,
   localparam int unsigned FB         = FW / 8,
   localparam int unsigned ID_W       = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
   localparam int unsigned OFF_W      = $clog2(BW),
   localparam int unsigned WORD_IDX_W = (CL_WORDS > 1) ? $clog2(CL_WORDS) : 1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   output logic                       empty_o,
   output logic                       full_o,
   output logic                       busy_o,
   input  logic [NLINE_W-1:0]         check_nline_i,
   output logic                       check_hit_o,
   input  logic                       alloc_i,
   output logic                       alloc_ready_o,
   input  logic [NLINE_W-1:0]         alloc_nline_i,
   input  logic [WAYS-1:0]            alloc_way_i,
   input  logic [BW-1:0]              alloc_be_i,
   output logic                       rd_o,
   output logic [SET_W-1:0]           rd_set_o,
   output logic [WORD_IDX_W-1:0]      rd_word_o,
   output logic [WAYS-1:0]            rd_way_o,
   input  logic [FW-1:0]              rd_data_i,
   output logic                       ack_o,
   output logic [NLINE_W-1:0]         ack_nline_o,
   output logic                       ack_err_o,
   output logic                       mem_req_valid_o,
   input  logic                       mem_req_ready_i,
   output logic [NLINE_W+OFF_W-1:0]   mem_req_addr_o,
   output logic [7:0]                 mem_req_len_o,
   output logic [ID_W-1:0]            mem_req_id_o,
   output logic                       mem_w_valid_o,
   input  logic                       mem_w_ready_i,
   output logic [FW-1:0]              mem_w_data_o,
   output logic [FB-1:0]              mem_w_be_o,
   output logic                       mem_w_last_o,
   input  logic                       mem_resp_valid_i,
   input  logic [ID_W-1:0]            mem_resp_id_i,
   input  logic                       mem_resp_err_i
);

   localparam int unsigned CNT_W = $clog2(F) + 1;

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

   state_e              state_q, state_d;
   logic [ENTRIES-1:0]  valid_q, valid_d;
   logic [NLINE_W-1:0]  nline_q [ENTRIES];
   logic [SET_W-1:0]    set_q;
   logic [WAYS-1:0]     way_q;
   logic [BW-1:0]       be_q;
   logic                req_valid_q, req_valid_d;
   logic [NLINE_W-1:0]  req_nline_q;
   logic [ID_W-1:0]     req_id_q;
   logic                rd_pend_q;
   logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
   logic [CNT_W-1:0]    cap_cnt_q, cap_cnt_d;
   logic                wv_q, wv_d;
   logic [FW-1:0]       wdata_q;
   logic [FB-1:0]       wbe_q;
   logic                wlast_q;

   logic                full, clean_alloc, alloc_ready, alloc_dirty;
   logic                w_hs, rd_send, ack_any, hit;
   logic [ID_W-1:0]     free_idx;
   logic [ENTRIES-1:0]  ack_vec;
   logic [NLINE_W-1:0]  ack_nline;
   logic [FB-1:0]       flit_be;

   assign full        = &valid_q;
   // A clean line needs no write-back, so it is accepted even when full.
   assign clean_alloc = (PARTIAL_WB != 0) && (alloc_be_i == '0);
   assign alloc_ready = rst_ni && (state_q == IDLE) &&
                        (clean_alloc || (!full && !req_valid_q));
   assign alloc_dirty = alloc_i && alloc_ready && !clean_alloc;
   assign w_hs        = wv_q && mem_w_ready_i;
   // One read in flight at a time; its data must find the output register free.
   assign rd_send     = (state_q == SEND) && !rd_pend_q && (!wv_q || w_hs) &&
                        (rd_cnt_q < CNT_W'(F));

   // Lowest-index free entry
   always_comb begin
      free_idx = '0;
      for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
         if (!valid_q[i]) free_idx = ID_W'(i);
      end
   end

   // Response decode, acked line lookup and directory check
   always_comb begin
      ack_vec   = '0;
      ack_nline = '0;
      hit       = 1'b0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
         ack_vec[i] = mem_resp_valid_i && valid_q[i] && (mem_resp_id_i == ID_W'(i));
         if (ack_vec[i]) ack_nline = ack_nline | nline_q[i];
         if (valid_q[i] && !ack_vec[i] && (nline_q[i] == check_nline_i)) hit = 1'b1;
      end
   end
   assign ack_any = |ack_vec;

   // Byte enables of the flit being captured
   always_comb begin
      flit_be = '1;
      if (PARTIAL_WB != 0) flit_be = be_q[int'(cap_cnt_q) * int'(FB) +: FB];
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q & ~ack_vec;
      req_valid_d = req_valid_q;
      rd_cnt_d    = rd_cnt_q;
      cap_cnt_d   = cap_cnt_q;
      wv_d        = wv_q;

      case (state_q)
         IDLE: if (alloc_dirty) state_d = SEND;
         SEND: if (w_hs && wlast_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (alloc_dirty) begin
         valid_d[free_idx] = 1'b1;
         req_valid_d       = 1'b1;
         rd_cnt_d          = CNT_W'(1);
         cap_cnt_d         = '0;
      end else begin
         if (req_valid_q && mem_req_ready_i) req_valid_d = 1'b0;
         if (rd_send)   rd_cnt_d  = rd_cnt_q + CNT_W'(1);
         if (rd_pend_q) cap_cnt_d = cap_cnt_q + CNT_W'(1);
      end

      if (rd_pend_q)  wv_d = 1'b1;
      else if (w_hs)  wv_d = 1'b0;
   end

   // Control state
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         req_valid_q <= 1'b0;
         rd_pend_q   <= 1'b0;
         rd_cnt_q    <= '0;
         cap_cnt_q   <= '0;
         wv_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         req_valid_q <= req_valid_d;
         rd_pend_q   <= rd_o;
         rd_cnt_q    <= rd_cnt_d;
         cap_cnt_q   <= cap_cnt_d;
         wv_q        <= wv_d;
      end
   end

   // Payload storage, qualified by the valid bits above
   always_ff @(posedge clk_i) begin
      if (alloc_dirty) begin
         nline_q[free_idx] <= alloc_nline_i;
         set_q             <= alloc_nline_i[SET_W-1:0];
         way_q             <= alloc_way_i;
         be_q              <= alloc_be_i;
         req_nline_q       <= alloc_nline_i;
         req_id_q          <= free_idx;
      end
      if (rd_pend_q) begin
         wdata_q <= rd_data_i;
         wbe_q   <= flit_be;
         wlast_q <= (cap_cnt_q == CNT_W'(F - 1));
      end
   end

   // The first read is issued in the alloc cycle from the incoming request.
   assign rd_o      = alloc_dirty || rd_send;
   assign rd_set_o  = alloc_dirty ? alloc_nline_i[SET_W-1:0] : (rd_send ? set_q : '0);
   assign rd_way_o  = alloc_dirty ? alloc_way_i : (rd_send ? way_q : '0);
   assign rd_word_o = rd_send ? WORD_IDX_W'(32'(rd_cnt_q) * AW) : '0;

   assign mem_req_valid_o = req_valid_q;
   assign mem_req_addr_o  = req_valid_q ? {req_nline_q, {OFF_W{1'b0}}} : '0;
   assign mem_req_len_o   = req_valid_q ? 8'(F - 1) : '0;
   assign mem_req_id_o    = req_valid_q ? req_id_q : '0;

   assign mem_w_valid_o = wv_q;
   assign mem_w_data_o  = wv_q ? wdata_q : '0;
   assign mem_w_be_o    = wv_q ? wbe_q : '0;
   assign mem_w_last_o  = wv_q && wlast_q;

   assign ack_o       = ack_any;
   assign ack_nline_o = ack_nline;
   assign ack_err_o   = ack_any && mem_resp_err_i;

   assign check_hit_o   = hit;
   assign empty_o       = ~|valid_q;
   assign full_o        = full;
   assign busy_o        = (state_q == SEND);
   assign alloc_ready_o = alloc_ready;

endmodule

// File: tb/tb_hpdcache_flush_pwb.sv
// Self-checking bench for hpdcache_flush_pwb (3-entry directory, other
// parameters at their defaults). A behavioural model predicts entry ids,
// requests and the flit stream of each line from the cache contents.
module tb_hpdcache_flush_pwb;

   localparam int unsigned NLINE_W = 26;
   localparam int unsigned SET_W   = 7;
   localparam int unsigned WAYS    = 4;
   localparam int unsigned CLW     = 8;
   localparam int unsigned AW      = 2;
   localparam int unsigned WORD_W  = 64;
   localparam int unsigned ENTRIES = 3;
   localparam int unsigned FW      = AW * WORD_W;
   localparam int unsigned F       = CLW / AW;
   localparam int unsigned BW      = CLW * WORD_W / 8;
   localparam int unsigned FB      = FW / 8;
   localparam int unsigned ID_W    = 2;
   localparam int unsigned ADDR_W  = NLINE_W + 6;

   logic clk_i = 1'b0;
   logic rst_ni;
   logic empty_o, full_o, busy_o;
   logic [NLINE_W-1:0] check_nline_i;
   logic check_hit_o;
   logic alloc_i, alloc_ready_o;
   logic [NLINE_W-1:0] alloc_nline_i;
   logic [WAYS-1:0] alloc_way_i;
   logic [BW-1:0] alloc_be_i;
   logic rd_o;
   logic [SET_W-1:0] rd_set_o;
   logic [2:0] rd_word_o;
   logic [WAYS-1:0] rd_way_o;
   logic [FW-1:0] rd_data_i;
   logic ack_o, ack_err_o;
   logic [NLINE_W-1:0] ack_nline_o;
   logic mem_req_valid_o, mem_req_ready_i;
   logic [ADDR_W-1:0] mem_req_addr_o;
   logic [7:0] mem_req_len_o;
   logic [ID_W-1:0] mem_req_id_o;
   logic mem_w_valid_o, mem_w_ready_i, mem_w_last_o;
   logic [FW-1:0] mem_w_data_o;
   logic [FB-1:0] mem_w_be_o;
   logic mem_resp_valid_i, mem_resp_err_i;
   logic [ID_W-1:0] mem_resp_id_i;

   hpdcache_flush_pwb #(
      .NLINE_W(NLINE_W), .SET_W(SET_W), .WAYS(WAYS), .CL_WORDS(CLW), .AW(AW),
      .WORD_W(WORD_W), .ENTRIES(ENTRIES), .PARTIAL_WB(1)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .empty_o(empty_o), .full_o(full_o), .busy_o(busy_o),
      .check_nline_i(check_nline_i), .check_hit_o(check_hit_o),
      .alloc_i(alloc_i), .alloc_ready_o(alloc_ready_o), .alloc_nline_i(alloc_nline_i),
      .alloc_way_i(alloc_way_i), .alloc_be_i(alloc_be_i),
      .rd_o(rd_o), .rd_set_o(rd_set_o), .rd_word_o(rd_word_o), .rd_way_o(rd_way_o),
      .rd_data_i(rd_data_i),
      .ack_o(ack_o), .ack_nline_o(ack_nline_o), .ack_err_o(ack_err_o),
      .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
      .mem_req_addr_o(mem_req_addr_o), .mem_req_len_o(mem_req_len_o), .mem_req_id_o(mem_req_id_o),
      .mem_w_valid_o(mem_w_valid_o), .mem_w_ready_i(mem_w_ready_i), .mem_w_data_o(mem_w_data_o),
      .mem_w_be_o(mem_w_be_o), .mem_w_last_o(mem_w_last_o),
      .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_id_i(mem_resp_id_i),
      .mem_resp_err_i(mem_resp_err_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [FW-1:0] data;
      logic [FB-1:0] be;
      logic          last;
   } flit_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        len;
      logic [ID_W-1:0]   id;
   } req_t;

   flit_t flits_q[$];
   req_t  reqs_q[$];
   flit_t mon_f;
   req_t  mon_r;

   int n_cmp = 0;
   int n_fail = 0;
   int req_mode = 0;
   int w_mode = 0;
   bit tog = 1'b0;

   bit               mvalid [ENTRIES];
   logic [NLINE_W-1:0] mnline [ENTRIES];

   // Cache word contents as a function of set, way and word index
   function automatic logic [63:0] gen_word(input logic [SET_W-1:0] s, input logic [WAYS-1:0] w,
                                            input int unsigned j);
      return {8'hC3, 1'b0, s, 4'h0, w, 8'(j), 32'(s * 7919 + j * 131 + w * 17) ^ 32'h5A5A_0F0F};
   endfunction

   // Cache data array: one-cycle read latency, garbage when not reading
   always @(posedge clk_i) begin
      if (rd_o)
         rd_data_i <= {gen_word(rd_set_o, rd_way_o, int'(rd_word_o) + 1),
                       gen_word(rd_set_o, rd_way_o, int'(rd_word_o))};
      else
         rd_data_i <= {$urandom(), $urandom(), $urandom(), $urandom()};
   end

   // Record every handshake on the memory channels
   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (mem_w_valid_o && mem_w_ready_i) begin
            mon_f.data = mem_w_data_o;
            mon_f.be   = mem_w_be_o;
            mon_f.last = mem_w_last_o;
            flits_q.push_back(mon_f);
         end
         if (mem_req_valid_o && mem_req_ready_i) begin
            mon_r.addr = mem_req_addr_o;
            mon_r.len  = mem_req_len_o;
            mon_r.id   = mem_req_id_o;
            reqs_q.push_back(mon_r);
         end
      end
   end

   function automatic int model_free();
      for (int i = 0; i < int'(ENTRIES); i++) if (!mvalid[i]) return i;
      return -1;
   endfunction

   task automatic drive_readies();
      if (req_mode == 0) mem_req_ready_i = 1'b1;
      else               mem_req_ready_i = ($urandom_range(0, 2) == 0);
      case (w_mode)
         0: mem_w_ready_i = 1'b1;
         1: begin tog = ~tog; mem_w_ready_i = tog; end
         default: mem_w_ready_i = 1'($urandom_range(0, 1));
      endcase
   endtask

   // Write back one dirty line and compare request and flits with the model
   task automatic do_line(input logic [NLINE_W-1:0] nl, input logic [WAYS-1:0] way,
                          input logic [BW-1:0] be, output int id);
      flit_t exp;
      bit done, stalled;
      logic [FW-1:0] hd;
      logic [FB-1:0] hb;
      logic hl;
      id = model_free();
      n_cmp++;
      if (id < 0) begin
         n_fail++;
         $display("FAIL line_free_entry: got none, want a free entry");
         return;
      end
      flits_q.delete();
      reqs_q.delete();
      alloc_i = 1'b1; alloc_nline_i = nl; alloc_way_i = way; alloc_be_i = be;
      drive_readies();
      @(negedge clk_i);
      n_cmp++;
      if (alloc_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL line_alloc_ready: got %b want 1", alloc_ready_o);
      end
      n_cmp++;
      if ({rd_o, rd_word_o, rd_set_o, rd_way_o} !== {1'b1, 3'd0, nl[SET_W-1:0], way}) begin
         n_fail++;
         $display("FAIL line_first_read: got rd=%b word=%0d set=%h way=%b want 1 0 %h %b",
                  rd_o, rd_word_o, rd_set_o, rd_way_o, nl[SET_W-1:0], way);
      end
      mvalid[id] = 1'b1;
      mnline[id] = nl;
      done = 1'b0;
      stalled = 1'b0;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         @(posedge clk_i); #1;
         alloc_i = 1'b0;
         if (cyc > 0 && reqs_q.size() == 1 && flits_q.size() == int'(F)) done = 1'b1;
         else begin
            drive_readies();
            @(negedge clk_i);
            if (cyc == 0) begin
               n_cmp++;
               if ({mem_req_valid_o, mem_req_addr_o, mem_req_len_o, mem_req_id_o} !==
                   {1'b1, nl, 6'd0, 8'(F - 1), ID_W'(id)}) begin
                  n_fail++;
                  $display("FAIL line_req_fields: got v=%b addr=%h len=%0d id=%0d want 1 %h %0d %0d",
                           mem_req_valid_o, mem_req_addr_o, mem_req_len_o, mem_req_id_o,
                           {nl, 6'd0}, F - 1, id);
               end
            end
            if (stalled) begin
               n_cmp++;
               if ({mem_w_valid_o, mem_w_data_o, mem_w_be_o, mem_w_last_o} !== {1'b1, hd, hb, hl}) begin
                  n_fail++;
                  $display("FAIL stall_stable: got v=%b data=%h be=%h want 1 %h %h",
                           mem_w_valid_o, mem_w_data_o, mem_w_be_o, hd, hb);
               end
            end
            stalled = mem_w_valid_o && !mem_w_ready_i;
            hd = mem_w_data_o; hb = mem_w_be_o; hl = mem_w_last_o;
         end
      end
      n_cmp++;
      if (!done) begin
         n_fail++;
         $display("FAIL line_timeout: got %0d reqs %0d flits want 1 %0d", reqs_q.size(), flits_q.size(), F);
         @(posedge clk_i); #1;
      end
      n_cmp++;
      if (busy_o !== 1'b0) begin
         n_fail++; $display("FAIL line_busy_after: got %b want 0", busy_o);
      end
      n_cmp++;
      if (reqs_q.size() != 1 || reqs_q[0] !== {nl, 6'd0, 8'(F - 1), ID_W'(id)}) begin
         n_fail++; $display("FAIL line_req_count: got %0d reqs want 1 matching", reqs_q.size());
      end
      n_cmp++;
      if (flits_q.size() != int'(F)) begin
         n_fail++; $display("FAIL line_flit_count: got %0d want %0d", flits_q.size(), F);
      end
      for (int k = 0; k < int'(F); k++) begin
         exp.data = {gen_word(nl[SET_W-1:0], way, 2 * k + 1), gen_word(nl[SET_W-1:0], way, 2 * k)};
         exp.be   = be[k * FB +: FB];
         exp.last = (k == int'(F) - 1);
         n_cmp++;
         if (k >= flits_q.size() || flits_q[k] !== exp) begin
            n_fail++;
            $display("FAIL line_flit%0d: got data=%h be=%h last=%b want data=%h be=%h last=%b", k,
                     (k < flits_q.size()) ? flits_q[k].data : '0, (k < flits_q.size()) ? flits_q[k].be : '0,
                     (k < flits_q.size()) ? flits_q[k].last : 1'b0, exp.data, exp.be, exp.last);
         end
      end
   endtask

   // Memory response for one id, checked against directory model
   task automatic respond(input logic [ID_W-1:0] id, input bit err);
      bit exp_ack;
      exp_ack = (int'(id) < int'(ENTRIES)) && mvalid[int'(id) % ENTRIES];
      mem_resp_valid_i = 1'b1; mem_resp_id_i = id; mem_resp_err_i = err;
      check_nline_i = exp_ack ? mnline[id] : NLINE_W'($urandom());
      @(negedge clk_i);
      n_cmp++;
      if (ack_o !== exp_ack) begin
         n_fail++; $display("FAIL resp_ack id%0d: got %b want %b", id, ack_o, exp_ack);
      end
      if (exp_ack) begin
         n_cmp++;
         if ({ack_nline_o, ack_err_o} !== {mnline[id], err}) begin
            n_fail++;
            $display("FAIL resp_fields id%0d: got nline=%h err=%b want %h %b", id, ack_nline_o, ack_err_o,
                     mnline[id], err);
         end
         n_cmp++;
         if (check_hit_o !== 1'b0) begin
            n_fail++; $display("FAIL resp_hit_masked id%0d: got %b want 0", id, check_hit_o);
         end
      end
      @(posedge clk_i); #1;
      mem_resp_valid_i = 1'b0;
      if (exp_ack) mvalid[id] = 1'b0;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      alloc_i = 1'b1; alloc_be_i = '1; mem_resp_valid_i = 1'b1; mem_resp_id_i = '0;
      repeat (2) @(posedge clk_i);
      #1;
      @(negedge clk_i);
      n_cmp++;
      if ({empty_o, full_o, busy_o, alloc_ready_o, rd_o, mem_req_valid_o, mem_w_valid_o, ack_o, check_hit_o}
          !== 9'b1_0000_0000) begin
         n_fail++;
         $display("FAIL reset_status: got e=%b f=%b b=%b ar=%b rd=%b rv=%b wv=%b ack=%b hit=%b want 1 then 0s",
                  empty_o, full_o, busy_o, alloc_ready_o, rd_o, mem_req_valid_o, mem_w_valid_o, ack_o, check_hit_o);
      end
      n_cmp++;
      if ({mem_req_addr_o, mem_req_len_o, mem_req_id_o, mem_w_data_o, mem_w_be_o, mem_w_last_o,
           rd_set_o, rd_word_o, rd_way_o, ack_nline_o, ack_err_o} !== '0) begin
         n_fail++; $display("FAIL reset_fields: got nonzero want 0 (addr=%h wdata=%h)", mem_req_addr_o, mem_w_data_o);
      end
      @(posedge clk_i); #1;
      alloc_i = 1'b0; mem_resp_valid_i = 1'b0;
      rst_ni = 1'b1;
      @(negedge clk_i);
      n_cmp++;
      if ({alloc_ready_o, empty_o, busy_o} !== 3'b110) begin
         n_fail++; $display("FAIL reset_release: got ar=%b e=%b b=%b want 1 1 0", alloc_ready_o, empty_o, busy_o);
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_basic();
      int id;
      req_mode = 0; w_mode = 0;
      do_line(26'h123, 4'b0010, '1, id);
      check_nline_i = 26'h123;
      @(negedge clk_i);
      n_cmp++;
      if ({check_hit_o, empty_o, flits_q[0].be} !== {1'b1, 1'b0, 16'hFFFF}) begin
         n_fail++; $display("FAIL basic_hit: got hit=%b empty=%b be0=%h want 1 0 ffff", check_hit_o, empty_o,
                            flits_q[0].be);
      end
      @(posedge clk_i); #1;
      respond(ID_W'(id), 1'b0);
      @(negedge clk_i);
      n_cmp++;
      if (empty_o !== 1'b1) begin
         n_fail++; $display("FAIL basic_freed: got empty=%b want 1", empty_o);
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_partial();
      int id;
      do_line(NLINE_W'($urandom()), 4'b1000, BW'(1) << 20, id);
      n_cmp++;
      if (flits_q.size() < 2 || flits_q[1].be !== 16'h0010) begin
         n_fail++; $display("FAIL partial_byte20: flit1 be wrong, want 0010");
      end
      respond(ID_W'(id), 1'b0);
   endtask

   task automatic test_full_clean_err();
      int id;
      logic [NLINE_W-1:0] base;
      base = NLINE_W'($urandom()) & 26'h3FF_FFF0;
      for (int i = 0; i < 3; i++) do_line(base + NLINE_W'(i), WAYS'(1 << i), {BW{1'b1}} >> (8 * i), id);
      alloc_i = 1'b1; alloc_be_i = 64'hF0; alloc_nline_i = base + 26'h8;
      @(negedge clk_i);
      n_cmp++;
      if ({full_o, alloc_ready_o, rd_o} !== 3'b100) begin
         n_fail++; $display("FAIL full_dirty_blocked: got f=%b ar=%b rd=%b want 1 0 0", full_o, alloc_ready_o, rd_o);
      end
      @(posedge clk_i); #1;
      alloc_be_i = '0;
      @(negedge clk_i);
      n_cmp++;
      if ({alloc_ready_o, rd_o} !== 2'b10) begin
         n_fail++; $display("FAIL clean_ready: got ar=%b rd=%b want 1 0", alloc_ready_o, rd_o);
      end
      @(posedge clk_i); #1;
      alloc_i = 1'b0;
      @(negedge clk_i);
      n_cmp++;
      if ({mem_req_valid_o, busy_o, full_o, empty_o} !== 4'b0010) begin
         n_fail++; $display("FAIL clean_no_effect: got rv=%b b=%b f=%b e=%b want 0 0 1 0", mem_req_valid_o,
                            busy_o, full_o, empty_o);
      end
      @(posedge clk_i); #1;
      respond(2'd3, 1'b0);
      // error ack on entry 1 together with a dirty alloc: alloc must stay blocked
      mem_resp_valid_i = 1'b1; mem_resp_id_i = 2'd1; mem_resp_err_i = 1'b1;
      check_nline_i = mnline[1];
      alloc_i = 1'b1; alloc_be_i = 64'h1;
      @(negedge clk_i);
      n_cmp++;
      if ({ack_o, ack_err_o, ack_nline_o, check_hit_o, alloc_ready_o, rd_o} !== {2'b11, mnline[1], 3'b000}) begin
         n_fail++; $display("FAIL err_ack: got ack=%b err=%b nline=%h hit=%b ar=%b want 1 1 %h 0 0",
                            ack_o, ack_err_o, ack_nline_o, check_hit_o, alloc_ready_o, mnline[1]);
      end
      @(posedge clk_i); #1;
      mem_resp_valid_i = 1'b0; alloc_i = 1'b0; mem_resp_err_i = 1'b0;
      mvalid[1] = 1'b0;
      @(negedge clk_i);
      n_cmp++;
      if ({full_o, busy_o, mem_req_valid_o, check_hit_o} !== 4'b0000) begin
         n_fail++; $display("FAIL err_freed: got f=%b b=%b rv=%b hit=%b want 0s", full_o, busy_o,
                            mem_req_valid_o, check_hit_o);
      end
      @(posedge clk_i); #1;
      respond(2'd1, 1'b0);
      do_line(base + 26'h5, 4'b0100, 64'hFF00_0000_0000_00FF, id);
      n_cmp++;
      if (id != 1) begin
         n_fail++; $display("FAIL reuse_entry: got %0d want 1", id);
      end
      for (int i = 0; i < 3; i++) respond(ID_W'(i), 1'($urandom_range(0, 1)));
   endtask

   task automatic test_stall_random();
      int id;
      logic [BW-1:0] be;
      req_mode = 0; w_mode = 1;
      do_line(NLINE_W'($urandom()), 4'b0001, {$urandom(), $urandom()}, id);
      respond(ID_W'(id), 1'b0);
      req_mode = 1; w_mode = 2;
      for (int n = 0; n < 8; n++) begin
         if (model_free() < 0) respond(ID_W'($urandom_range(0, ENTRIES - 1)), 1'($urandom_range(0, 1)));
         be = {$urandom(), $urandom()} & {$urandom(), $urandom()};
         if (be == '0) be = 64'h8000_0000_0000_0000;
         do_line(NLINE_W'($urandom()), WAYS'(1 << $urandom_range(0, WAYS - 1)), be, id);
      end
      for (int i = 0; i < int'(ENTRIES); i++) respond(ID_W'(i), 1'b0);
      req_mode = 0; w_mode = 0;
   endtask

   task automatic test_reset_mid();
      logic [NLINE_W-1:0] nl;
      nl = NLINE_W'($urandom());
      req_mode = 0; w_mode = 0;
      flits_q.delete();
      alloc_i = 1'b1; alloc_nline_i = nl; alloc_way_i = 4'b0010; alloc_be_i = '1;
      drive_readies();
      check_nline_i = nl;
      for (int cyc = 0; cyc < 50 && flits_q.size() < 2; cyc++) begin
         @(posedge clk_i); #1;
         alloc_i = 1'b0;
      end
      n_cmp++;
      if (flits_q.size() != 2) begin
         n_fail++; $display("FAIL rstmid_two_flits: got %0d want 2", flits_q.size());
      end
      rst_ni = 1'b0;
      #1;
      n_cmp++;
      if ({empty_o, full_o, busy_o, alloc_ready_o, rd_o, mem_req_valid_o, mem_w_valid_o, mem_w_last_o,
           ack_o, check_hit_o, mem_w_data_o} !== {1'b1, {(9 + FW){1'b0}}}) begin
         n_fail++;
         $display("FAIL rstmid_outputs: got e=%b b=%b wv=%b rd=%b hit=%b data=%h want e=1 rest 0",
                  empty_o, busy_o, mem_w_valid_o, rd_o, check_hit_o, mem_w_data_o);
      end
      for (int i = 0; i < int'(ENTRIES); i++) mvalid[i] = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      repeat (12) @(posedge clk_i);
      #1;
      n_cmp++;
      if ({32'(flits_q.size()), busy_o, empty_o} !== {32'd2, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL rstmid_no_flit3: got %0d flits b=%b e=%b want 2 0 1", flits_q.size(),
                            busy_o, empty_o);
      end
   endtask

   initial begin
      rst_ni = 1'b0;
      alloc_i = 1'b0; alloc_nline_i = '0; alloc_way_i = '0; alloc_be_i = '0;
      check_nline_i = '0;
      mem_req_ready_i = 1'b0; mem_w_ready_i = 1'b0;
      mem_resp_valid_i = 1'b0; mem_resp_id_i = '0; mem_resp_err_i = 1'b0;
      for (int i = 0; i < int'(ENTRIES); i++) begin mvalid[i] = 1'b0; mnline[i] = '0; end
      test_reset();
      test_basic();
      test_partial();
      test_full_clean_err();
      test_stall_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
